// File: rtl/sd_image_loader.sv
// Streams one RGB565 image from an SPI SD reader into frame RAM, one sector per read command.
// Optional watchdog: define LOADER_TIMEOUT_EN to enable the WAIT timeout and sticky error flag.
module sd_image_loader #(
  parameter int ADDR_W          = 17,
  parameter int IMG_PIXELS      = 76800,
  parameter int SECTOR_BYTES    = 512,
  parameter int SECTORS_PER_IMG = 300,
  parameter int BASE_SECTOR     = 0,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [1:0]        image_select,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              start_read,
  output logic [31:0]       sector_addr,
  input  logic [7:0]        sd_data,
  input  logic              sd_data_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_we
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
`ifdef LOADER_TIMEOUT_EN
  localparam logic [2:0] ST_ERR  = 3'd5;
`endif

  logic [2:0]  state;
  logic [31:0] pix_cnt;
  logic [31:0] sec_cnt;
  logic [31:0] byte_cnt;
  logic [7:0]  low_byte;
  logic        accept;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] wdog;
  // A timed-out loader sits in ERR and takes a fresh request just like IDLE.
  assign accept = load_req && ((state == ST_IDLE) || (state == ST_ERR));
`else
  assign accept = load_req && (state == ST_IDLE);
  assign error  = 1'b0;
`endif

  assign start_read = (state == ST_REQ);
  assign done       = (state == ST_DONE);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      sector_addr <= '0;
      pix_cnt     <= '0;
      sec_cnt     <= '0;
      byte_cnt    <= '0;
      low_byte    <= '0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_we      <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      wdog        <= '0;
      error       <= 1'b0;
`endif
    end else begin
      ram_we <= 1'b0;
      if (accept) begin
        sector_addr <= 32'(BASE_SECTOR + int'(image_select) * SECTORS_PER_IMG);
        pix_cnt     <= '0;
        sec_cnt     <= '0;
        byte_cnt    <= '0;
        busy        <= 1'b1;
        state       <= ST_REQ;
`ifdef LOADER_TIMEOUT_EN
        error       <= 1'b0;
`endif
      end else begin
        case (state)
          ST_REQ: begin
            state <= ST_WAIT;
`ifdef LOADER_TIMEOUT_EN
            wdog  <= '0;
`endif
          end
          ST_WAIT: begin
            if (sd_data_valid) begin
              byte_cnt <= byte_cnt + 32'd1;
              if (!byte_cnt[0]) begin
                low_byte <= sd_data;
              end else if (pix_cnt < IMG_PIXELS) begin
                // Surplus bytes beyond the image are dropped; address and data hold.
                ram_we   <= 1'b1;
                ram_data <= {sd_data, low_byte};
                ram_addr <= pix_cnt[ADDR_W-1:0];
                pix_cnt  <= pix_cnt + 32'd1;
              end
              if (byte_cnt == SECTOR_BYTES - 1) state <= ST_NEXT;
`ifdef LOADER_TIMEOUT_EN
              wdog <= '0;
            end else if (wdog == TIMEOUT_CYCLES - 1) begin
              busy  <= 1'b0;
              error <= 1'b1;
              state <= ST_ERR;
            end else begin
              wdog <= wdog + 32'd1;
`endif
            end
          end
          ST_NEXT: begin
            if (sec_cnt == SECTORS_PER_IMG - 1) begin
              state <= ST_DONE;
            end else begin
              sec_cnt     <= sec_cnt + 32'd1;
              sector_addr <= sector_addr + 32'd1;
              byte_cnt    <= '0;
              state       <= ST_REQ;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
